// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ready fetches to instruction
// memory and presents pc+4 / instruction to the IF/ID register with stall/flush semantics.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_plus_4_if,
   output logic [31:0] instruction_if,
   output logic        fetch_valid
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   hold_buf_q, hold_buf_d;
   logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
   logic [XLEN-1:0]   tgt_aligned;
   logic [XLEN-1:0]   pc_inc;

   assign tgt_aligned = {branch_target[XLEN-1:2], 2'b00};
   assign pc_inc      = pc_q + XLEN'(4);

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         hold_buf_q <= '0;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         hold_buf_q <= hold_buf_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   // Next-state and output logic; branch_taken outranks stall in every state
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      hold_buf_d     = hold_buf_q;
      pend_tgt_d     = pend_tgt_q;
      imem_req       = 1'b0;
      instruction_if = NOP_INSTR;
      fetch_valid    = 1'b0;

      unique case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (!imem_ready) begin
               if (branch_taken) begin
                  pend_tgt_d = tgt_aligned;
                  state_d    = DROP;
               end
            end else if (branch_taken) begin
               pc_d = tgt_aligned;
            end else if (!stall) begin
               instruction_if = imem_rdata;
               fetch_valid    = 1'b1;
               pc_d           = pc_inc;
            end else begin
               instruction_if = imem_rdata;
               fetch_valid    = 1'b1;
               hold_buf_d     = imem_rdata;
               state_d        = HOLD;
            end
         end
         HOLD: begin
            instruction_if = hold_buf_q;
            fetch_valid    = 1'b1;
            if (branch_taken) begin
               pc_d    = tgt_aligned;
               state_d = FETCH;
            end else if (!stall) begin
               pc_d    = pc_inc;
               state_d = FETCH;
            end
         end
         DROP: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               pc_d    = branch_taken ? tgt_aligned : pend_tgt_q;
               state_d = FETCH;
            end else if (branch_taken) begin
               pend_tgt_d = tgt_aligned;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      if (!reset_n) begin
         imem_req = 1'b0;
      end
   end

   // pc is frozen while a fetch is outstanding, so it is also the DROP address
   assign imem_addr    = pc_q;
   assign pc_plus_4_if = pc_inc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit: one cycle per vector plus an
// asynchronous-reset sequence taken from inside DROP.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          NVEC   = 27;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_plus_4_if;
   logic [31:0] instruction_if;
   logic        fetch_valid;

   int n_checks;
   int n_pass;

   typedef struct {
      logic        rst_n;
      logic        stl;
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic        e_valid;
      logic [31:0] e_pc4;
   } vec_t;

   vec_t vecs [NVEC];

   if_fetch_unit #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .pc_plus_4_if   (pc_plus_4_if),
      .instruction_if (instruction_if),
      .fetch_valid    (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
   endtask

   task automatic apply(input int i);
      reset_n       = vecs[i].rst_n;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      imem_ready    = vecs[i].rdy;
      imem_rdata    = vecs[i].rdata;
      @(negedge clk);
      chk("imem_req",       i, 32'(imem_req),    32'(vecs[i].e_req));
      chk("imem_addr",      i, imem_addr,        vecs[i].e_addr);
      chk("instruction_if", i, instruction_if,   vecs[i].e_instr);
      chk("fetch_valid",    i, 32'(fetch_valid), 32'(vecs[i].e_valid));
      chk("pc_plus_4_if",   i, pc_plus_4_if,     vecs[i].e_pc4);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      // rst stl br tgt rdy rdata | req addr instr valid pc4
      vecs[0]  = '{0,0,0,32'h0,         0,32'h0,         0,32'h0040_0000,32'h0,         0,32'h0040_0004};
      vecs[1]  = '{1,0,0,32'h0,         1,32'h2008_0005, 1,32'h0040_0000,32'h2008_0005, 1,32'h0040_0004};
      vecs[2]  = '{1,0,0,32'h0,         1,32'h1111_1111, 1,32'h0040_0004,32'h1111_1111, 1,32'h0040_0008};
      vecs[3]  = '{1,0,0,32'h0,         0,32'hDEAD_BEEF, 1,32'h0040_0008,32'h0,         0,32'h0040_000C};
      vecs[4]  = '{1,0,0,32'h0,         0,32'hDEAD_BEEF, 1,32'h0040_0008,32'h0,         0,32'h0040_000C};
      vecs[5]  = '{1,0,0,32'h0,         1,32'h2222_2222, 1,32'h0040_0008,32'h2222_2222, 1,32'h0040_000C};
      vecs[6]  = '{1,1,0,32'h0,         1,32'h8C09_0000, 1,32'h0040_000C,32'h8C09_0000, 1,32'h0040_0010};
      vecs[7]  = '{1,1,0,32'h0,         0,32'h0,         0,32'h0040_000C,32'h8C09_0000, 1,32'h0040_0010};
      vecs[8]  = '{1,1,0,32'h0,         0,32'h0,         0,32'h0040_000C,32'h8C09_0000, 1,32'h0040_0010};
      vecs[9]  = '{1,0,0,32'h0,         0,32'h0,         0,32'h0040_000C,32'h8C09_0000, 1,32'h0040_0010};
      vecs[10] = '{1,0,0,32'h0,         1,32'h3333_3333, 1,32'h0040_0010,32'h3333_3333, 1,32'h0040_0014};
      vecs[11] = '{1,0,1,32'h0040_0100, 0,32'h0,         1,32'h0040_0014,32'h0,         0,32'h0040_0018};
      vecs[12] = '{1,1,0,32'h0,         0,32'h0,         1,32'h0040_0014,32'h0,         0,32'h0040_0018};
      vecs[13] = '{1,0,1,32'h0040_0200, 0,32'h0,         1,32'h0040_0014,32'h0,         0,32'h0040_0018};
      vecs[14] = '{1,0,0,32'h0,         1,32'h4444_4444, 1,32'h0040_0014,32'h0,         0,32'h0040_0018};
      vecs[15] = '{1,0,0,32'h0,         1,32'h5555_5555, 1,32'h0040_0200,32'h5555_5555, 1,32'h0040_0204};
      vecs[16] = '{1,0,1,32'h0040_0300, 0,32'h0,         1,32'h0040_0204,32'h0,         0,32'h0040_0208};
      vecs[17] = '{1,0,1,32'h0040_0500, 1,32'h0,         1,32'h0040_0204,32'h0,         0,32'h0040_0208};
      vecs[18] = '{1,0,0,32'h0,         1,32'h6666_6666, 1,32'h0040_0500,32'h6666_6666, 1,32'h0040_0504};
      vecs[19] = '{1,0,1,32'h0040_0103, 1,32'h7777_7777, 1,32'h0040_0504,32'h0,         0,32'h0040_0508};
      vecs[20] = '{1,1,0,32'h0,         1,32'h8888_8888, 1,32'h0040_0100,32'h8888_8888, 1,32'h0040_0104};
      vecs[21] = '{1,1,1,32'h0040_0040, 0,32'h0,         0,32'h0040_0100,32'h8888_8888, 1,32'h0040_0104};
      vecs[22] = '{1,0,0,32'h0,         1,32'h9999_9999, 1,32'h0040_0040,32'h9999_9999, 1,32'h0040_0044};
      vecs[23] = '{1,0,1,32'hFFFF_FFFF, 1,32'h0,         1,32'h0040_0044,32'h0,         0,32'h0040_0048};
      vecs[24] = '{1,0,0,32'h0,         1,32'hAAAA_AAAA, 1,32'hFFFF_FFFC,32'hAAAA_AAAA, 1,32'h0000_0000};
      vecs[25] = '{1,0,0,32'h0,         0,32'h0,         1,32'h0000_0000,32'h0,         0,32'h0000_0004};
      vecs[26] = '{1,0,1,32'h0000_1000, 0,32'h0,         1,32'h0000_0000,32'h0,         0,32'h0000_0004};

      reset_n       = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      imem_ready    = 1'b0;
      imem_rdata    = '0;

      for (int i = 0; i < NVEC; i++) apply(i);

      // DUT now in DROP; an asynchronous reset pulse must return it to FETCH at RESET_PC
      branch_taken = 1'b0;
      imem_ready   = 1'b0;
      reset_n      = 1'b0;
      #1;
      chk("rst_req",  100, 32'(imem_req), 32'h0);
      chk("rst_addr", 100, imem_addr,     RST_PC);
      #1;
      reset_n    = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'hBBBB_BBBB;
      @(negedge clk);
      chk("post_rst_req",   101, 32'(imem_req),    32'h1);
      chk("post_rst_valid", 101, 32'(fetch_valid), 32'h1);
      chk("post_rst_instr", 101, instruction_if,   32'hBBBB_BBBB);
      chk("post_rst_addr",  101, imem_addr,        RST_PC);
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_next_addr", 102, imem_addr,    RST_PC + 32'd4);
      chk("post_rst_nop",       102, instruction_if, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
